or_gate: RTL and testbench
==========================

Name: or_gate

Overview:
- Registered, parameterizable bitwise 2-input OR unit with valid qualification and an activity counter.
- Computes y = a | b per bit, one clock after a qualified input.
- Also reports a reduction-OR flag and a saturating count of input beats that produced a nonzero result.
- Leaf-level utility block used wherever a clocked, observable OR of two operand vectors is needed.

Parameters:
- WIDTH, 1, bit width of operands a, b and result y (legal range 1..64).
- CNT_W, 8, bit width of the hi_count activity counter (legal range 1..32).

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  qualifies a and b in the current cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- clr_count  input  1  synchronous clear of hi_count.
- y  output  WIDTH  registered bitwise OR result.
- out_valid  output  1  high for one cycle when y holds a freshly computed result.
- y_any  output  1  registered reduction OR of the latest result (high if any bit of y is 1).
- hi_count  output  CNT_W  saturating count of accepted beats where (a|b) != 0.

Behaviour:
- All state updates on the rising edge of clk; no asynchronous paths; all outputs are driven directly from registers.
- Reset (rst=1 at a clock edge) has priority over everything else:
  - y = 0, y_any = 0, out_valid = 0, hi_count = 0.
  - in_valid and clr_count are ignored in that cycle.
- Normal operation (rst=0):
  - out_valid <= in_valid. Latency is exactly 1 cycle; back-to-back in_valid gives back-to-back out_valid. There is no backpressure.
  - If in_valid=1: y <= a | b and y_any <= |(a | b).
  - If in_valid=0: y and y_any hold their previous values; out_valid = 0.
- hi_count rules, in priority order:
  - clr_count=1: hi_count <= 0, even if an increment condition exists in the same cycle (clear wins).
  - Else if in_valid=1 and (a|b) != 0 and hi_count != all-ones: hi_count <= hi_count + 1.
  - At all-ones, hi_count saturates and holds. It never wraps.
  - Otherwise hold.
- Truth per bit: 0|0=0, 0|1=1, 1|0=1, 1|1=1. Bits are independent; there is no carry or cross-bit interaction except y_any.
- Reset asserted mid-stream: the in-flight result is discarded. The cycle after reset deasserts shows out_valid=0 unless in_valid was high in that first non-reset cycle.
- Operand values are don't-care when in_valid=0. X on unqualified operands must not propagate into y, y_any or hi_count.

Decomposition:
- Package or_gate_pkg holds:
  - default localparams OR_WIDTH_DEF=1 and OR_CNT_W_DEF=8;
  - a function or_reduce(vector) used for y_any and the counter condition.
- One natural sub-module: or_gate_sat_cnt, a CNT_W-bit saturating up-counter.
  - Inputs: clk, rst, clr, inc.
  - Output: count.
  - Priority: rst over clr over inc.
- The remaining datapath stays in or_gate.

Test Plan:
- Truth table, WIDTH=1: apply (a,b) = 00, 01, 10, 11 with in_valid=1 on consecutive cycles -> one cycle later y = 0, 1, 1, 1; out_valid=1 each cycle; hi_count ends at 3.
- Hold behaviour: apply a=1, b=0 with in_valid=1, then drop in_valid for 5 cycles with a=0, b=0 -> y stays 1, out_valid=0 during hold, hi_count unchanged at 1.
- Multi-bit, WIDTH=8: a=8'hA0, b=8'h05 -> y=8'hA5, y_any=1. Then a=0, b=0 -> y=8'h00, y_any=0, and hi_count does not increment for the zero beat.
- Saturation, CNT_W=2: 5 consecutive beats with a=1 -> hi_count reads 1, 2, 3, 3, 3. Then clr_count=1 together with an in_valid nonzero beat -> hi_count=0.
- Reset priority: with y=1 and hi_count=2, assert rst together with in_valid=1, a=1 -> next cycle y=0, y_any=0, out_valid=0, hi_count=0.
- Reset release: deassert rst and apply in_valid=1, a=0, b=1 in the same cycle -> out_valid=1 and y=1 on the following edge.

Source files
------------

// File: rtl/or_gate_pkg.sv
// rtl/or_gate_pkg.sv - shared defaults and helpers for the registered OR unit
package or_gate_pkg;

   localparam int OR_WIDTH_DEF = 1;
   localparam int OR_CNT_W_DEF = 8;

   // Callers zero-extend to 64 bits so one function serves every WIDTH
   function automatic logic or_reduce(input logic [63:0] vec);
      return |vec;
   endfunction

endpackage

// File: rtl/or_gate_sat_cnt.sv
// rtl/or_gate_sat_cnt.sv - saturating up-counter with clear
module or_gate_sat_cnt
   import or_gate_pkg::*;
#(
   parameter int CNT_W = OR_CNT_W_DEF
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_clr,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_count
);

   logic [CNT_W-1:0] r_count;

   // Reset beats clear, clear beats increment; holds at all-ones instead of wrapping
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/or_gate.sv
// rtl/or_gate.sv - registered bitwise OR with valid, any-bit flag and activity count
module or_gate
   import or_gate_pkg::*;
#(
   parameter int WIDTH = OR_WIDTH_DEF,
   parameter int CNT_W = OR_CNT_W_DEF
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_in_valid,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_clr_count,
   output logic [WIDTH-1:0] o_y,
   output logic             o_out_valid,
   output logic             o_y_any,
   output logic [CNT_W-1:0] o_hi_count
);

   logic [WIDTH-1:0] w_or;
   logic [63:0]      w_or_ext;
   logic             w_nonzero;
   logic             w_inc;

   logic [WIDTH-1:0] r_y;
   logic             r_y_any;
   logic             r_out_valid;

   assign w_or      = i_a | i_b;
   assign w_or_ext  = 64'(w_or);
   assign w_nonzero = or_reduce(w_or_ext);
   // Gating with valid keeps unqualified (possibly X) operands out of the counter
   assign w_inc     = i_in_valid & w_nonzero;

   // Result registers: capture only on qualified beats, valid pulses one cycle later
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_y         <= '0;
         r_y_any     <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= i_in_valid;
         if (i_in_valid) begin
            r_y     <= w_or;
            r_y_any <= w_nonzero;
         end
      end
   end

   or_gate_sat_cnt #(
      .CNT_W (CNT_W)
   ) u_sat_cnt (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_clr   (i_clr_count),
      .i_inc   (w_inc),
      .o_count (o_hi_count)
   );

   assign o_y         = r_y;
   assign o_y_any     = r_y_any;
   assign o_out_valid = r_out_valid;

endmodule

// File: tb/tb_or_gate.sv
// tb/tb_or_gate.sv - scoreboard bench for or_gate at WIDTH=1/CNT_W=8 and WIDTH=8/CNT_W=2
module tb_or_gate;

   typedef struct packed {
      logic       ov1;
      logic       y1;
      logic       any1;
      logic [7:0] c1;
      logic       ov8;
      logic [7:0] y8;
      logic       any8;
      logic [1:0] c8;
   } exp_t;

   logic       clk = 1'b0;
   logic       r_rst = 1'b1;
   logic       r_v = 1'b0;
   logic       r_clr = 1'b0;
   logic [7:0] r_a = '0;
   logic [7:0] r_b = '0;

   logic       w_ov1, w_y1, w_any1;
   logic [7:0] w_c1;
   logic       w_ov8, w_any8;
   logic [7:0] w_y8;
   logic [1:0] w_c8;
   exp_t       obs;

   // model state
   logic       m_y1, m_any1, m_y8_any;
   logic [7:0] m_c1, m_y8;
   logic [1:0] m_c8;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   or_gate #(.WIDTH(1), .CNT_W(8)) u_w1 (
      .i_clk       (clk),
      .i_rst       (r_rst),
      .i_in_valid  (r_v),
      .i_a         (r_a[0:0]),
      .i_b         (r_b[0:0]),
      .i_clr_count (r_clr),
      .o_y         (w_y1),
      .o_out_valid (w_ov1),
      .o_y_any     (w_any1),
      .o_hi_count  (w_c1)
   );

   or_gate #(.WIDTH(8), .CNT_W(2)) u_w8 (
      .i_clk       (clk),
      .i_rst       (r_rst),
      .i_in_valid  (r_v),
      .i_a         (r_a),
      .i_b         (r_b),
      .i_clr_count (r_clr),
      .o_y         (w_y8),
      .o_out_valid (w_ov8),
      .o_y_any     (w_any8),
      .o_hi_count  (w_c8)
   );

   assign obs = {w_ov1, w_y1, w_any1, w_c1, w_ov8, w_y8, w_any8, w_c8};

   task automatic step(input logic rst, input logic v, input logic clr,
                       input logic [7:0] a, input logic [7:0] b);
      exp_t e;
      @(negedge clk);
      r_rst = rst; r_v = v; r_clr = clr; r_a = a; r_b = b;
      if (rst) begin
         m_y1 = 1'b0; m_any1 = 1'b0; m_c1 = '0;
         m_y8 = '0; m_y8_any = 1'b0; m_c8 = '0;
      end else begin
         if (v) begin
            m_y1 = a[0] | b[0];
            m_any1 = a[0] | b[0];
            m_y8 = a | b;
            m_y8_any = ((a | b) != 8'h00);
         end
         if (clr) m_c1 = '0;
         else if (v && (a[0] | b[0]) && m_c1 != 8'hFF) m_c1 = m_c1 + 8'd1;
         if (clr) m_c8 = '0;
         else if (v && ((a | b) != 8'h00) && m_c8 != 2'd3) m_c8 = m_c8 + 2'd1;
      end
      e = {(!rst && v), m_y1, m_any1, m_c1, (!rst && v), m_y8, m_y8_any, m_c8};
      sb.push_back(e);
   endtask

   task automatic test_reset();
      exp_t e;
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF);
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if (obs !== e) begin errors++; $display("FAIL reset[%0d]: got %h expected %h", i, obs, e); end
      end
      checks++;
      if (obs !== '0) begin errors++; $display("FAIL reset_zero: got %h expected 0", obs); end
   endtask

   task automatic test_truth_table();
      exp_t e;
      logic [1:0] ab;
      for (int i = 0; i < 4; i++) begin
         ab = 2'(i);
         step(1'b0, 1'b1, 1'b0, {7'd0, ab[1]}, {7'd0, ab[0]});
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if (obs !== e) begin errors++; $display("FAIL truth[%0d]: got %h expected %h", i, obs, e); end
         checks++;
         if (w_y1 !== (i != 0) || w_ov1 !== 1'b1) begin
            errors++; $display("FAIL truth_y[%0d]: got y=%b ov=%b expected y=%b ov=1", i, w_y1, w_ov1, (i != 0));
         end
      end
      checks++;
      if (w_c1 !== 8'd3) begin errors++; $display("FAIL truth_count: got %0d expected 3", w_c1); end
   endtask

   task automatic test_hold();
      exp_t e;
      step(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL hold_clr: got %h expected %h", obs, e); end
      step(1'b0, 1'b1, 1'b0, 8'h01, 8'h00);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL hold_load: got %h expected %h", obs, e); end
      for (int i = 0; i < 5; i++) begin
         if (i < 3) step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
         else       step(1'b0, 1'b0, 1'b0, 8'hxx, 8'hxx);
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if (obs !== e) begin errors++; $display("FAIL hold[%0d]: got %h expected %h", i, obs, e); end
      end
      checks++;
      if (w_y1 !== 1'b1 || w_ov1 !== 1'b0 || w_c1 !== 8'd1) begin
         errors++; $display("FAIL hold_final: got y=%b ov=%b cnt=%0d expected y=1 ov=0 cnt=1", w_y1, w_ov1, w_c1);
      end
   endtask

   task automatic test_multibit();
      exp_t e;
      step(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
      @(posedge clk); #1;
      e = sb.pop_front();
      step(1'b0, 1'b1, 1'b0, 8'hA0, 8'h05);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (obs !== e || w_y8 !== 8'hA5 || w_any8 !== 1'b1) begin
         errors++; $display("FAIL multibit_a5: got %h (y8=%h) expected %h (y8=a5)", obs, w_y8, e);
      end
      step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (obs !== e || w_y8 !== 8'h00 || w_any8 !== 1'b0 || w_c8 !== 2'd1) begin
         errors++; $display("FAIL multibit_zero: got %h (cnt8=%0d) expected %h (cnt8=1)", obs, w_c8, e);
      end
   endtask

   task automatic test_saturation();
      exp_t e;
      logic [1:0] want [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      step(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
      @(posedge clk); #1;
      e = sb.pop_front();
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b1, 1'b0, 8'h01, 8'h00);
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if (obs !== e || w_c8 !== want[i]) begin
            errors++; $display("FAIL sat[%0d]: got %h (cnt8=%0d) expected %h (cnt8=%0d)", i, obs, w_c8, e, want[i]);
         end
      end
      step(1'b0, 1'b1, 1'b1, 8'h01, 8'h00);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (obs !== e || w_c8 !== 2'd0 || w_c1 !== 8'd0) begin
         errors++; $display("FAIL sat_clr_wins: got %h expected %h", obs, e);
      end
   endtask

   task automatic test_reset_priority();
      exp_t e;
      for (int i = 0; i < 2; i++) begin
         step(1'b0, 1'b1, 1'b0, 8'h01, 8'h00);
         @(posedge clk); #1;
         e = sb.pop_front();
      end
      checks++;
      if (obs !== e || w_c1 !== 8'd2 || w_y1 !== 1'b1) begin
         errors++; $display("FAIL rstpri_setup: got %h expected %h", obs, e);
      end
      step(1'b1, 1'b1, 1'b0, 8'h01, 8'h00);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (obs !== e || obs !== '0) begin errors++; $display("FAIL rstpri: got %h expected %h", obs, e); end
      step(1'b0, 1'b1, 1'b0, 8'h00, 8'h01);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (obs !== e || w_ov1 !== 1'b1 || w_y1 !== 1'b1) begin
         errors++; $display("FAIL rst_release: got %h expected %h", obs, e);
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      logic v, clr;
      logic [7:0] a, b;
      for (int i = 0; i < 40; i++) begin
         v   = ($urandom_range(0, 3) != 0);
         clr = ($urandom_range(0, 9) == 0);
         a   = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
         b   = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
         step(1'b0, v, clr, a, b);
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if (obs !== e) begin errors++; $display("FAIL b2b[%0d]: got %h expected %h", i, obs, e); end
      end
   endtask

   initial begin
      m_y1 = 1'b0; m_any1 = 1'b0; m_c1 = '0;
      m_y8 = '0; m_y8_any = 1'b0; m_c8 = '0;
      test_reset();
      test_truth_table();
      test_hold();
      test_multibit();
      test_saturation();
      test_reset_priority();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
